// File: rtl/intf_or_ctrl.sv
// rtl/intf_or_ctrl.sv - two-client sequencer/arbiter in front of one intf_or unit
//
// Purpose: accepts an (a,b) operand pair from client C0 or C1, issues a then b
// to the shared unit, collects y and hands it back to the submitting client.
// Only one job is in flight at a time.
//
// Ports:
//   CLK, RST                       clock, asynchronous active-high reset
//   cK_a_data/cK_b_data/cK_en/cK_rdy   client K submit method (K = 0,1)
//   cK_y_en/cK_y_data/cK_y_rdy     client K result method
//   a_data/a_en/a_rdy              unit method a
//   b_data/b_en/b_rdy              unit method b
//   y_en/y_data/y_rdy              unit method y
//   tmo                            sticky watchdog flag (ORCTL_TIMEOUT_EN only)
//
// Build option: define ORCTL_TIMEOUT_EN to add the WAIT_Y watchdog (TMO_CYC
// cycles), the tmo port, and draining of late y results while idle.
module intf_or_ctrl #(
    parameter int W = 8
`ifdef ORCTL_TIMEOUT_EN
    ,
    parameter int TMO_CYC = 64
`endif
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [W-1:0] c0_a_data,
    input  logic [W-1:0] c0_b_data,
    input  logic         c0_en,
    output logic         c0_rdy,
    input  logic         c0_y_en,
    output logic [W-1:0] c0_y_data,
    output logic         c0_y_rdy,
    input  logic [W-1:0] c1_a_data,
    input  logic [W-1:0] c1_b_data,
    input  logic         c1_en,
    output logic         c1_rdy,
    input  logic         c1_y_en,
    output logic [W-1:0] c1_y_data,
    output logic         c1_y_rdy,
`ifdef ORCTL_TIMEOUT_EN
    output logic         tmo,
`endif
    output logic [W-1:0] a_data,
    output logic         a_en,
    input  logic         a_rdy,
    output logic [W-1:0] b_data,
    output logic         b_en,
    input  logic         b_rdy,
    output logic         y_en,
    input  logic [W-1:0] y_data,
    input  logic         y_rdy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_Y, RESP} state_t;

    state_t         state_q, state_d;
    logic           ptr_q, ptr_d;
    logic           owner_q, owner_d;
    logic           a_done_q, a_done_d;
    logic [W-1:0]   a_op_q, a_op_d;
    logic [W-1:0]   b_op_q, b_op_d;
    logic [W-1:0]   result_q, result_d;

    logic c0_rdy_c, c1_rdy_c, a_en_c, b_en_c, y_en_c;

`ifdef ORCTL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TMO_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
`endif

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        a_done_d = a_done_q;
        a_op_d   = a_op_q;
        b_op_d   = b_op_q;
        result_d = result_q;
        c0_rdy_c = 1'b0;
        c1_rdy_c = 1'b0;
        a_en_c   = 1'b0;
        b_en_c   = 1'b0;
        y_en_c   = 1'b0;
`ifdef ORCTL_TIMEOUT_EN
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
`endif
        unique case (state_q)
            IDLE: begin
                // Time-slot round robin: only the slot owner may submit.
                c0_rdy_c = !ptr_q;
                c1_rdy_c = ptr_q;
`ifdef ORCTL_TIMEOUT_EN
                // A y that arrives after the watchdog gave up is thrown away.
                y_en_c   = y_rdy;
`endif
                a_done_d = 1'b0;
                if (c0_en && c0_rdy_c) begin
                    a_op_d  = c0_a_data;
                    b_op_d  = c0_b_data;
                    owner_d = 1'b0;
                    state_d = ISSUE;
                end else if (c1_en && c1_rdy_c) begin
                    a_op_d  = c1_a_data;
                    b_op_d  = c1_b_data;
                    owner_d = 1'b1;
                    state_d = ISSUE;
                end else begin
                    ptr_d = !ptr_q;
                end
            end
            ISSUE: begin
                // b only after a has fired in an earlier cycle.
                a_en_c = a_rdy && !a_done_q;
                b_en_c = b_rdy && a_done_q;
                if (a_en_c) a_done_d = 1'b1;
                if (b_en_c) begin
                    state_d = WAIT_Y;
`ifdef ORCTL_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            WAIT_Y: begin
                y_en_c = y_rdy;
                if (y_rdy) begin
                    result_d = y_data;
                    state_d  = RESP;
                end
`ifdef ORCTL_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TMO_CYC - 1)) begin
                    result_d = '0;
                    tmo_d    = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                if (owner_q ? c1_y_en : c0_y_en) begin
                    state_d = IDLE;
                    ptr_d   = !owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            owner_q  <= 1'b0;
            a_done_q <= 1'b0;
            a_op_q   <= '0;
            b_op_q   <= '0;
            result_q <= '0;
`ifdef ORCTL_TIMEOUT_EN
            cnt_q    <= '0;
            tmo_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            a_done_q <= a_done_d;
            a_op_q   <= a_op_d;
            b_op_q   <= b_op_d;
            result_q <= result_d;
`ifdef ORCTL_TIMEOUT_EN
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
`endif
        end
    end

    // Handshake outputs are forced low while RST is high, since IDLE would
    // otherwise advertise c0_rdy during reset.
    assign c0_rdy    = c0_rdy_c && !RST;
    assign c1_rdy    = c1_rdy_c && !RST;
    assign a_en      = a_en_c && !RST;
    assign b_en      = b_en_c && !RST;
    assign y_en      = y_en_c && !RST;
    assign a_data    = a_op_q;
    assign b_data    = b_op_q;
    assign c0_y_rdy  = (state_q == RESP) && !owner_q && !RST;
    assign c1_y_rdy  = (state_q == RESP) && owner_q && !RST;
    assign c0_y_data = c0_y_rdy ? result_q : '0;
    assign c1_y_data = c1_y_rdy ? result_q : '0;
`ifdef ORCTL_TIMEOUT_EN
    assign tmo       = tmo_q;
`endif

endmodule
